// File: rtl/midi_parser_if.sv
// UART-byte-in / decoded-event-out bundle for midi_parser.
// master = byte source plus event sink (bench or UART side); slave = the parser.
interface midi_parser_if #(
    parameter int BYTE_WIDTH = 8
);
    logic [BYTE_WIDTH-1:0] data_in;
    logic                  data_in_ready;
    logic                  event_valid;
    logic [1:0]            event_type;
    logic [3:0]            event_channel;
    logic [6:0]            event_data1;
    logic [6:0]            event_data2;
    logic                  stray_data;

    modport master (
        output data_in, data_in_ready,
        input  event_valid, event_type, event_channel,
        input  event_data1, event_data2, stray_data
    );

    modport slave (
        input  data_in, data_in_ready,
        output event_valid, event_type, event_channel,
        output event_data1, event_data2, stray_data
    );
endinterface

// File: rtl/midi_parser.sv
// MIDI byte-stream parser: running status, real-time/SysEx filtering, note/CC/bend events.
// Optional macro MIDI_CHANNEL_FILTER_EN: only LISTEN_CHANNEL produces events.
module midi_parser #(
    parameter int BYTE_WIDTH     = 8,
    parameter int LISTEN_CHANNEL = 0
) (
    input logic      clock_50_000_000,
    input logic      reset,
    midi_parser_if.slave bus
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT_D1 = 2'd1;
    localparam logic [1:0] WAIT_D2 = 2'd2;
    localparam logic [1:0] SYSEX   = 2'd3;

    if (BYTE_WIDTH < 8 || LISTEN_CHANNEL < 0 || LISTEN_CHANNEL > 15) begin : g_bad_config
        $error("midi_parser: BYTE_WIDTH must be >= 8 and LISTEN_CHANNEL 0-15");
    end

    logic [1:0] state;
    logic       rs_valid;
    logic [3:0] status_nib;
    logic [3:0] chan;
    logic [6:0] data1;

    logic [7:0] rx;
    logic       is_status;
    logic       is_realtime;
    logic       two_byte;
    logic       reportable;
    logic       chan_ok;

    assign rx          = bus.data_in[7:0];
    assign is_status   = rx[7];
    assign is_realtime = (rx[7:3] == 5'b11111);
    assign two_byte    = (status_nib != 4'hC) && (status_nib != 4'hD);
    assign reportable  = (status_nib == 4'h8) || (status_nib == 4'h9) ||
                         (status_nib == 4'hB) || (status_nib == 4'hE);

`ifdef MIDI_CHANNEL_FILTER_EN
    assign chan_ok = (chan == 4'(LISTEN_CHANNEL));
`else
    assign chan_ok = 1'b1;
`endif

    always_ff @(posedge clock_50_000_000) begin
        if (reset) begin
            state             <= IDLE;
            rs_valid          <= 1'b0;
            status_nib        <= '0;
            chan              <= '0;
            data1             <= '0;
            bus.event_valid   <= 1'b0;
            bus.event_type    <= '0;
            bus.event_channel <= '0;
            bus.event_data1   <= '0;
            bus.event_data2   <= '0;
            bus.stray_data    <= 1'b0;
        end else begin
            bus.event_valid <= 1'b0;
            bus.stray_data  <= 1'b0;
            if (bus.data_in_ready) begin
                if (is_status) begin
                    // Real-time bytes leave every piece of parser state untouched.
                    if (!is_realtime) begin
                        if (rx == 8'hF0) begin
                            state    <= SYSEX;
                            rs_valid <= 1'b0;
                        end else if (rx[7:4] == 4'hF) begin
                            state    <= IDLE;
                            rs_valid <= 1'b0;
                        end else begin
                            status_nib <= rx[7:4];
                            chan       <= rx[3:0];
                            rs_valid   <= 1'b1;
                            state      <= WAIT_D1;
                        end
                    end
                end else begin
                    case (state)
                        IDLE, WAIT_D1: begin
                            // IDLE with valid running status behaves exactly like WAIT_D1.
                            if (state == WAIT_D1 || rs_valid) begin
                                data1 <= rx[6:0];
                                state <= two_byte ? WAIT_D2 : IDLE;
                            end else begin
                                bus.stray_data <= 1'b1;
                            end
                        end
                        WAIT_D2: begin
                            state <= IDLE;
                            if (reportable && chan_ok) begin
                                bus.event_valid   <= 1'b1;
                                bus.event_channel <= chan;
                                bus.event_data1   <= data1;
                                bus.event_data2   <= rx[6:0];
                                case (status_nib)
                                    4'h8:    bus.event_type <= 2'd0;
                                    4'h9:    bus.event_type <= (rx[6:0] == 7'd0) ? 2'd0 : 2'd1;
                                    4'hB:    bus.event_type <= 2'd2;
                                    default: bus.event_type <= 2'd3;
                                endcase
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_parser.sv
// Directed bench for midi_parser: hand-computed expectations checked with immediate assertions.
module tb_midi_parser;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    int   ev_cnt      = 0;
    int   stray_cnt   = 0;
    int   ev_base;
    int   stray_base;
    logic [19:0] last_fields = '0;

    always #10 clk = ~clk;

    midi_parser_if #(.BYTE_WIDTH(8)) bus ();

    midi_parser #(
        .BYTE_WIDTH(8),
        .LISTEN_CHANNEL(0)
    ) dut (
        .clock_50_000_000(clk),
        .reset(rst),
        .bus(bus)
    );

    always @(posedge clk) begin
        #1;
        if (bus.event_valid === 1'b1) ev_cnt++;
        if (bus.stray_data === 1'b1) stray_cnt++;
    end

    function automatic logic passes(input logic [3:0] ch);
`ifdef MIDI_CHANNEL_FILTER_EN
        return ch == 4'd0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] fields();
        return {bus.event_type, bus.event_channel, bus.event_data1, bus.event_data2};
    endfunction

    task automatic check_event(input string tag, input logic [1:0] t, input logic [3:0] ch,
                               input logic [6:0] d1, input logic [6:0] d2);
        if (passes(ch)) begin
            check({tag, "_valid"}, 32'(bus.event_valid), 32'd1);
            last_fields = {t, ch, d1, d2};
            check({tag, "_fields"}, 32'(fields()), 32'(last_fields));
        end else begin
            check({tag, "_filtered"}, 32'(bus.event_valid), 32'd0);
        end
    endtask

    task automatic check_none(input string tag);
        check({tag, "_novalid"}, 32'(bus.event_valid), 32'd0);
    endtask

    task automatic check_hold(input string tag);
        check({tag, "_hold"}, 32'(fields()), 32'(last_fields));
    endtask

    task automatic check_zero(input string tag);
        check(tag, {11'd0, bus.event_valid, bus.stray_data, fields()}, 32'd0);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.data_in       = b;
        bus.data_in_ready = 1'b1;
        @(negedge clk);
        bus.data_in_ready = 1'b0;
    endtask

    initial begin
        rst               = 1'b1;
        bus.data_in       = '0;
        bus.data_in_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        rst = 1'b0;

        // Plain note on, channel 3.
        send(8'h93); send(8'h3C);
        check_none("non_d1");
        send(8'h64);
        check_event("non", 2'd1, 4'd3, 7'h3C, 7'h64);
        @(negedge clk);
        check_none("non_pulse_end");
        check_hold("non");

        // Running status, velocity 0 maps to note off.
        ev_base = ev_cnt;
        send(8'h90); send(8'h40); send(8'h50);
        check_event("rs1", 2'd1, 4'd0, 7'h40, 7'h50);
        send(8'h43); send(8'h00);
        check_event("rs2", 2'd0, 4'd0, 7'h43, 7'h00);
        check("rs_count", 32'(ev_cnt - ev_base), passes(4'd0) ? 32'd2 : 32'd0);

        // Real-time byte between data bytes.
        send(8'h90); send(8'h3C); send(8'hF8);
        check_none("rt_mid");
        send(8'h7F);
        check_event("rt", 2'd1, 4'd0, 7'h3C, 7'h7F);

        // SysEx swallowed, then a stray data byte.
        ev_base = ev_cnt; stray_base = stray_cnt;
        send(8'hF0); send(8'h7E); send(8'h01); send(8'hF7); send(8'h45);
        check("sysex_stray", 32'(bus.stray_data), 32'd1);
        check("sysex_events", 32'(ev_cnt - ev_base), 32'd0);
        check("sysex_stray_cnt", 32'(stray_cnt - stray_base), 32'd1);

        // Pitch bend, control change, program change.
        send(8'hE2); send(8'h00); send(8'h40);
        check_event("bend", 2'd3, 4'd2, 7'h00, 7'h40);
        send(8'hB2); send(8'h07); send(8'h7F);
        check_event("cc", 2'd2, 4'd2, 7'h07, 7'h7F);
        ev_base = ev_cnt; stray_base = stray_cnt;
        send(8'hC5); send(8'h10); send(8'h11);
        check("pc_events", 32'(ev_cnt - ev_base), 32'd0);
        check("pc_stray", 32'(stray_cnt - stray_base), 32'd0);
        check_hold("pc");

        // Poly aftertouch consumed silently.
        ev_base = ev_cnt;
        send(8'hA1); send(8'h10); send(8'h20);
        check("pat_events", 32'(ev_cnt - ev_base), 32'd0);

        // System common outside SysEx kills running status.
        stray_base = stray_cnt;
        send(8'hF3); send(8'h05);
        check("syscom_stray", 32'(stray_cnt - stray_base), 32'd1);

        // SysEx terminated by a channel-voice status byte.
        send(8'hF0); send(8'h01); send(8'h92); send(8'h30); send(8'h40);
        check_event("sysex_abort", 2'd1, 4'd2, 7'h30, 7'h40);

        // Abandoned partial message: new status in WAIT_D2.
        ev_base = ev_cnt;
        send(8'h94); send(8'h22); send(8'h84); send(8'h22); send(8'h33);
        check_event("abandon", 2'd0, 4'd4, 7'h22, 7'h33);
        check("abandon_count", 32'(ev_cnt - ev_base), passes(4'd4) ? 32'd1 : 32'd0);

        // data_in ignored while data_in_ready is low.
        ev_base = ev_cnt; stray_base = stray_cnt;
        @(negedge clk);
        bus.data_in = 8'h35;
        repeat (4) @(negedge clk);
        check("noready_events", 32'(ev_cnt - ev_base + stray_cnt - stray_base), 32'd0);

        // Back-to-back strobes give back-to-back pulses.
        @(negedge clk); bus.data_in = 8'h90; bus.data_in_ready = 1'b1;
        @(negedge clk); bus.data_in = 8'h40;
        @(negedge clk); bus.data_in = 8'h50;
        @(negedge clk); bus.data_in = 8'h41;
        check_event("b2b1", 2'd1, 4'd0, 7'h40, 7'h50);
        @(negedge clk); bus.data_in = 8'h51;
        check_none("b2b_gap");
        @(negedge clk); bus.data_in_ready = 1'b0;
        check_event("b2b2", 2'd1, 4'd0, 7'h41, 7'h51);

        // Reset mid-message.
        send(8'h90); send(8'h3C);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check_zero("midreset_zero");
        last_fields = '0;
        send(8'h64);
        check("midreset_stray", 32'(bus.stray_data), 32'd1);
        check_none("midreset");

        // Channel 1 note: filtered only when the channel filter is built in.
        ev_base = ev_cnt;
        send(8'h91); send(8'h3C); send(8'h64);
        check_event("chan1", 2'd1, 4'd1, 7'h3C, 7'h64);
        check("chan1_count", 32'(ev_cnt - ev_base), passes(4'd1) ? 32'd1 : 32'd0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
